alu_issue_ctrl: RTL and testbench

- Multicycle sequencer in front of the shared ALU core (5-bit op port, 4-bit encodings used).
- Accepts one decoded instruction per valid/ready handshake and registers its operands.
- Decodes opcode/funct into ALU op and In1/In2 mux selects, runs one ALU cycle, then returns the result on a valid/ready response port.
- Sits between decode and writeback/branch logic; the ALU core and its In1/In2 muxes are instanced beside it and driven from its ports.

---
 rtl/alu_issue_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Multicycle issue sequencer for the shared ALU core: IDLE -> EXEC -> RESP.
// Optional signed-overflow flag for add/sub/addi under `define ALU_ISSUE_OVF_EN.
module alu_issue_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [5:0]      req_opcode,
   input  logic [5:0]      req_funct,
   input  logic [XLEN-1:0] req_rs,
   input  logic [XLEN-1:0] req_rt,
   input  logic [15:0]     req_imm,
   input  logic [4:0]      req_shamt,
   output logic [XLEN-1:0] op_rs,
   output logic [XLEN-1:0] op_rt,
   output logic [15:0]     op_imm,
   output logic [XLEN-1:0] op_ex_imm,
   output logic [4:0]      op_shamt,
   output logic [1:0]      alu_in1_sel,
   output logic            alu_in2_sel,
   output logic [4:0]      alu_op,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_zero,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_result,
   output logic            rsp_zero,
   output logic            rsp_branch_taken,
   output logic            rsp_illegal,
   output logic            rsp_overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [4:0] OP_NONE = 5'b01111;

   state_t state, state_nxt;

   logic [5:0] opcode;
   logic [5:0] funct;

   logic [4:0] dec_op;
   logic [1:0] dec_in1;
   logic       dec_in2;
   logic       dec_illegal;
   logic       dec_beq;
   logic       dec_bne;
   logic       in_exec;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign in_exec   = (state == EXEC);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_rs    <= '0;
         op_rt    <= '0;
         op_imm   <= '0;
         op_shamt <= '0;
         opcode   <= '0;
         funct    <= '0;
      end else if (req_ready && req_valid) begin
         op_rs    <= req_rs;
         op_rt    <= req_rt;
         op_imm   <= req_imm;
         op_shamt <= req_shamt;
         opcode   <= req_opcode;
         funct    <= req_funct;
      end
   end

   assign op_ex_imm = {{(XLEN-16){op_imm[15]}}, op_imm};

   always_comb begin
      dec_op      = OP_NONE;
      dec_in1     = 2'b00;
      dec_in2     = 1'b0;
      dec_illegal = 1'b0;
      dec_beq     = 1'b0;
      dec_bne     = 1'b0;
      case (opcode)
         6'b000000: begin
            case (funct)
               6'b000000: begin dec_op = 5'b00000; dec_in2 = 1'b1; end
               6'b000010: begin dec_op = 5'b00001; dec_in2 = 1'b1; end
               6'b000011: begin dec_op = 5'b00010; dec_in2 = 1'b1; end
               6'b000100: dec_op = 5'b00011;
               6'b000110: dec_op = 5'b00100;
               6'b000111: dec_op = 5'b00101;
               6'b001000: dec_op = 5'b00111;
               6'b100000: dec_op = 5'b00110;
               6'b100010: dec_op = 5'b00111;
               6'b100100: dec_op = 5'b01000;
               6'b100101: dec_op = 5'b01001;
               6'b100110: dec_op = 5'b01010;
               6'b100111: dec_op = 5'b01011;
               6'b101010: dec_op = 5'b01100;
               6'b101011: dec_op = 5'b01101;
               default:   dec_illegal = 1'b1;
            endcase
         end
         6'b001000, 6'b001001, 6'b100011, 6'b101011: begin
            dec_op = 5'b00110; dec_in1 = 2'b01;
         end
         6'b001010: begin dec_op = 5'b01100; dec_in1 = 2'b01; end
         6'b001011: begin dec_op = 5'b01101; dec_in1 = 2'b01; end
         6'b001100: begin dec_op = 5'b01000; dec_in1 = 2'b10; end
         6'b001101: begin dec_op = 5'b01001; dec_in1 = 2'b10; end
         6'b001110: begin dec_op = 5'b01010; dec_in1 = 2'b10; end
         6'b001111: begin dec_op = 5'b01110; dec_in1 = 2'b10; end
         6'b000100: begin dec_op = 5'b00111; dec_beq = 1'b1; end
         6'b000101: begin dec_op = 5'b00111; dec_bne = 1'b1; end
         default:   dec_illegal = 1'b1;
      endcase
   end

   // Core and muxes see a neutral op outside EXEC so they idle at result 0.
   assign alu_op      = in_exec ? dec_op  : OP_NONE;
   assign alu_in1_sel = in_exec ? dec_in1 : 2'b00;
   assign alu_in2_sel = in_exec ? dec_in2 : 1'b0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_result       <= '0;
         rsp_zero         <= 1'b0;
         rsp_branch_taken <= 1'b0;
         rsp_illegal      <= 1'b0;
      end else if (in_exec) begin
         rsp_result       <= dec_illegal ? '0 : alu_result;
         rsp_zero         <= dec_illegal ? 1'b1 : alu_zero;
         rsp_branch_taken <= (dec_beq & alu_zero) | (dec_bne & ~alu_zero);
         rsp_illegal      <= dec_illegal;
      end
   end

`ifdef ALU_ISSUE_OVF_EN
   logic            is_add;
   logic            is_sub;
   logic            is_addi;
   logic [XLEN-1:0] add_b;
   logic            add_ovf;
   logic            sub_ovf;

   assign is_add  = (opcode == 6'b000000) && (funct == 6'b100000);
   assign is_sub  = (opcode == 6'b000000) && (funct == 6'b100010);
   assign is_addi = (opcode == 6'b001000);
   assign add_b   = is_addi ? op_ex_imm : op_rt;

   assign add_ovf = (add_b[XLEN-1] == op_rs[XLEN-1]) &&
                    (alu_result[XLEN-1] != op_rs[XLEN-1]);
   // sub computes rs - rt
   assign sub_ovf = (op_rs[XLEN-1] != op_rt[XLEN-1]) &&
                    (alu_result[XLEN-1] != op_rs[XLEN-1]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        rsp_overflow <= 1'b0;
      else if (in_exec) rsp_overflow <= ((is_add | is_addi) & add_ovf) |
                                        (is_sub & sub_ovf);
   end
`else
   assign rsp_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU core and In1/In2 muxes.
// Build with +define+ALU_ISSUE_OVF_EN to exercise the overflow flag.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_opcode;
   logic [5:0]  req_funct;
   logic [31:0] req_rs;
   logic [31:0] req_rt;
   logic [15:0] req_imm;
   logic [4:0]  req_shamt;
   logic [31:0] op_rs;
   logic [31:0] op_rt;
   logic [15:0] op_imm;
   logic [31:0] op_ex_imm;
   logic [4:0]  op_shamt;
   logic [1:0]  alu_in1_sel;
   logic        alu_in2_sel;
   logic [4:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_zero;
   logic        rsp_branch_taken;
   logic        rsp_illegal;
   logic        rsp_overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.XLEN(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_funct(req_funct),
      .req_rs(req_rs), .req_rt(req_rt),
      .req_imm(req_imm), .req_shamt(req_shamt),
      .op_rs(op_rs), .op_rt(op_rt), .op_imm(op_imm),
      .op_ex_imm(op_ex_imm), .op_shamt(op_shamt),
      .alu_in1_sel(alu_in1_sel), .alu_in2_sel(alu_in2_sel),
      .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .rsp_branch_taken(rsp_branch_taken),
      .rsp_illegal(rsp_illegal), .rsp_overflow(rsp_overflow)
   );

   // ALU core plus In1/In2 muxes; sub/slt compute In2 op In1 (rs op rt).
   logic [31:0] in1;
   logic [31:0] in2;
   always_comb begin
      case (alu_in1_sel)
         2'b00:   in1 = op_rt;
         2'b01:   in1 = op_ex_imm;
         2'b10:   in1 = {16'h0, op_imm};
         default: in1 = 32'h0;
      endcase
      in2 = alu_in2_sel ? {27'h0, op_shamt} : op_rs;
      case (alu_op)
         5'b00000: alu_result = in1 << in2[4:0];
         5'b00001: alu_result = in1 >> in2[4:0];
         5'b00010: alu_result = $unsigned($signed(in1) >>> in2[4:0]);
         5'b00011: alu_result = in1 << in2[4:0];
         5'b00100: alu_result = in1 >> in2[4:0];
         5'b00101: alu_result = $unsigned($signed(in1) >>> in2[4:0]);
         5'b00110: alu_result = in2 + in1;
         5'b00111: alu_result = in2 - in1;
         5'b01000: alu_result = in2 & in1;
         5'b01001: alu_result = in2 | in1;
         5'b01010: alu_result = in2 ^ in1;
         5'b01011: alu_result = ~(in2 | in1);
         5'b01100: alu_result = {31'h0, $signed(in2) < $signed(in1)};
         5'b01101: alu_result = {31'h0, in2 < in1};
         5'b01110: alu_result = {in1[15:0], 16'h0};
         default:  alu_result = 32'h0;
      endcase
      alu_zero = (alu_result == 32'h0);
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one request and leave the DUT in EXEC after the accepting edge.
   task automatic send(input logic [5:0] opc, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [15:0] imm, input logic [4:0] sh);
      req_opcode = opc;
      req_funct  = fn;
      req_rs     = rs;
      req_rt     = rt;
      req_imm    = imm;
      req_shamt  = sh;
      req_valid  = 1'b1;
      tick();
      req_valid  = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid) break;
         tick();
      end
      check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
   endtask

   task automatic ack();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic run(input string tag, input logic [5:0] opc,
                      input logic [5:0] fn, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [15:0] imm,
                      input logic [4:0] sh, input logic [31:0] exp_res,
                      input logic exp_zero, input logic exp_br,
                      input logic exp_ill);
      send(opc, fn, rs, rt, imm, sh);
      wait_rsp(tag);
      check({tag, "_result"}, rsp_result, exp_res);
      check({tag, "_zero"}, {31'h0, rsp_zero}, {31'h0, exp_zero});
      check({tag, "_branch"}, {31'h0, rsp_branch_taken}, {31'h0, exp_br});
      check({tag, "_illegal"}, {31'h0, rsp_illegal}, {31'h0, exp_ill});
      ack();
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      rsp_ready  = 1'b0;
      req_opcode = '0;
      req_funct  = '0;
      req_rs     = '0;
      req_rt     = '0;
      req_imm    = '0;
      req_shamt  = '0;
      tick();
      tick();
      check("rst_req_ready", {31'h0, req_ready}, 32'h1);
      check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("rst_alu_op", {27'h0, alu_op}, 32'h0000000F);
      check("rst_rsp_result", rsp_result, 32'h0);
      check("rst_op_rs", op_rs, 32'h0);
      reset = 1'b0;
      tick();

      // addi: latency and EXEC-cycle mux selects
      send(6'b001000, 6'h00, 32'd5, 32'h0, 16'hFFFF, 5'd0);
      check("addi_exec_in1", {30'h0, alu_in1_sel}, 32'h1);
      check("addi_exec_op", {27'h0, alu_op}, 32'h6);
      check("addi_exec_ready", {31'h0, req_ready}, 32'h0);
      check("addi_exec_valid", {31'h0, rsp_valid}, 32'h0);
      tick();
      check("addi_valid", {31'h0, rsp_valid}, 32'h1);
      check("addi_result", rsp_result, 32'd4);
      check("addi_resp_op", {27'h0, alu_op}, 32'h0000000F);
      ack();
      check("addi_idle_ready", {31'h0, req_ready}, 32'h1);
      check("addi_idle_valid", {31'h0, rsp_valid}, 32'h0);

      run("sll", 6'h00, 6'b000000, 32'h0, 32'h1, 16'h0, 5'd4,
          32'h10, 1'b0, 1'b0, 1'b0);
      run("sra", 6'h00, 6'b000011, 32'h0, 32'h80000000, 16'h0, 5'd4,
          32'hF8000000, 1'b0, 1'b0, 1'b0);
      run("lui", 6'b001111, 6'h00, 32'h0, 32'h0, 16'h1234, 5'd0,
          32'h12340000, 1'b0, 1'b0, 1'b0);
      run("ori", 6'b001101, 6'h00, 32'hF0000000, 32'h0, 16'h8001, 5'd0,
          32'hF0008001, 1'b0, 1'b0, 1'b0);
      run("slt", 6'h00, 6'b101010, 32'hFFFFFFFF, 32'h1, 16'h0, 5'd0,
          32'h1, 1'b0, 1'b0, 1'b0);
      run("sub", 6'h00, 6'b100010, 32'd10, 32'd3, 16'h0, 5'd0,
          32'd7, 1'b0, 1'b0, 1'b0);
      run("beq", 6'b000100, 6'h00, 32'd7, 32'd7, 16'h0, 5'd0,
          32'h0, 1'b1, 1'b1, 1'b0);
      run("bne", 6'b000101, 6'h00, 32'd7, 32'd7, 16'h0, 5'd0,
          32'h0, 1'b1, 1'b0, 1'b0);

      // Backpressure: response held, a competing request waits for IDLE.
      send(6'h00, 6'b100000, 32'd3, 32'd4, 16'h0, 5'd0);
      tick();
      req_opcode = 6'b001111;
      req_imm    = 16'h0001;
      req_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", {31'h0, rsp_valid}, 32'h1);
         check("bp_result", rsp_result, 32'd7);
         check("bp_ready", {31'h0, req_ready}, 32'h0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp_idle_ready", {31'h0, req_ready}, 32'h1);
      tick();
      req_valid = 1'b0;
      check("bp_next_exec_op", {27'h0, alu_op}, 32'h0000000E);
      wait_rsp("bp_next");
      check("bp_next_result", rsp_result, 32'h00010000);
      ack();

      run("ill_opc", 6'h3F, 6'h00, 32'd1, 32'd2, 16'h0, 5'd0,
          32'h0, 1'b1, 1'b0, 1'b1);
      run("ill_fn", 6'h00, 6'b000001, 32'd1, 32'd2, 16'h0, 5'd0,
          32'h0, 1'b1, 1'b0, 1'b1);

      // Reset mid-EXEC discards the add and clears every output.
      send(6'h00, 6'b100000, 32'd9, 32'd9, 16'h0, 5'd0);
      reset = 1'b1;
      #1;
      check("mid_rst_ready", {31'h0, req_ready}, 32'h1);
      check("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
      check("mid_rst_illegal", {31'h0, rsp_illegal}, 32'h0);
      check("mid_rst_zero", {31'h0, rsp_zero}, 32'h0);
      check("mid_rst_alu_op", {27'h0, alu_op}, 32'h0000000F);
      check("mid_rst_op_rs", op_rs, 32'h0);
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_valid", {31'h0, rsp_valid}, 32'h0);
      run("post_rst_add", 6'h00, 6'b100000, 32'd20, 32'd22, 16'h0, 5'd0,
          32'd42, 1'b0, 1'b0, 1'b0);

`ifdef ALU_ISSUE_OVF_EN
      send(6'h00, 6'b100000, 32'h7FFFFFFF, 32'h1, 16'h0, 5'd0);
      wait_rsp("ovf_add");
      check("ovf_add_result", rsp_result, 32'h80000000);
      check("ovf_add_flag", {31'h0, rsp_overflow}, 32'h1);
      ack();
      send(6'b001001, 6'h00, 32'h7FFFFFFF, 32'h0, 16'h0001, 5'd0);
      wait_rsp("ovf_addiu");
      check("ovf_addiu_result", rsp_result, 32'h80000000);
      check("ovf_addiu_flag", {31'h0, rsp_overflow}, 32'h0);
      ack();
      send(6'h00, 6'b100010, 32'h80000000, 32'h1, 16'h0, 5'd0);
      wait_rsp("ovf_sub");
      check("ovf_sub_result", rsp_result, 32'h7FFFFFFF);
      check("ovf_sub_flag", {31'h0, rsp_overflow}, 32'h1);
      ack();
`else
      send(6'h00, 6'b100000, 32'h7FFFFFFF, 32'h1, 16'h0, 5'd0);
      wait_rsp("noovf_add");
      check("noovf_add_result", rsp_result, 32'h80000000);
      check("noovf_add_flag", {31'h0, rsp_overflow}, 32'h0);
      ack();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
